// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: the machine word and the RAM handshake state.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single RAM port between instruction fetch and data access.
// Data has priority, but a starvation counter forces an instruction grant.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
)
(
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      iwait,
    output logic      dwait,
    output word_t     iload,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        IGRANT,
        DGRANT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    logic             dreq;
    logic             ram_done;

    assign dreq     = dREN | dWEN;
    assign ram_done = (ramstate == ACCESS);

    // BUSY, FREE and ERROR all hold the grant; a withdrawn request drops back to IDLE.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dreq && (starve_cnt < LIMIT))
                        state <= DGRANT;
                    else if (iREN)
                        state <= IGRANT;
                    else if (dreq)
                        state <= DGRANT;
                end
                IGRANT: begin
                    if (!iREN) begin
                        state <= IDLE;
                    end else if (ram_done) begin
                        state      <= IDLE;
                        starve_cnt <= '0;
                    end
                end
                DGRANT: begin
                    if (!dreq) begin
                        state <= IDLE;
                    end else if (ram_done) begin
                        state <= IDLE;
                        if (!iREN)
                            starve_cnt <= '0;
                        else if (starve_cnt < LIMIT)
                            starve_cnt <= starve_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Only the granted requester reaches the RAM; the other one keeps waiting.
    always_comb begin
        iwait    = iREN;
        dwait    = dreq;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (iREN && ram_done) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            DGRANT: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (dreq && ram_done) begin
                    dwait = 1'b0;
                    dload = dREN ? ramload : '0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Cycle-by-cycle vector bench for mem_arbiter with an expected-result queue.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam word_t IA = 32'h0000_0100;
    localparam word_t DA = 32'h0000_0040;
    localparam word_t DS = 32'hDEAD_BEEF;
    localparam word_t RL = 32'hCAFE_F00D;

    logic      CLK;
    logic      nRST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore, ramload;
    logic      iwait, dwait, ramREN, ramWEN;
    word_t     iload, dload, ramaddr, ramstore;
    ramstate_t ramstate;

    typedef struct {
        logic      rst;
        logic      i;
        logic      d;
        logic      w;
        ramstate_t rs;
        logic      e_iwait;
        logic      e_dwait;
        logic      e_ren;
        logic      e_wen;
        word_t     e_addr;
        word_t     e_store;
        word_t     e_iload;
        word_t     e_dload;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   row   = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .iwait    (iwait),
        .dwait    (dwait),
        .iload    (iload),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(logic r, logic i, logic d, logic w, ramstate_t rs,
                                logic ei, logic ed, logic er, logic ew,
                                word_t ea, word_t es, word_t eil, word_t edl);
        vec_t v;
        v.rst = r;     v.i = i;       v.d = d;      v.w = w;      v.rs = rs;
        v.e_iwait = ei; v.e_dwait = ed; v.e_ren = er; v.e_wen = ew;
        v.e_addr = ea; v.e_store = es; v.e_iload = eil; v.e_dload = edl;
        return v;
    endfunction

    task automatic cmp(input string name, input word_t got, input word_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL row%0d %s: got %h want %h", row, name, got, want);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        nRST     = ~v.rst;
        iREN     = v.i;
        dREN     = v.d;
        dWEN     = v.w;
        ramstate = v.rs;
        exp_q.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL row%0d scoreboard: got empty want entry", row);
            return;
        end
        e = exp_q.pop_front();
        cmp("iwait",    word_t'(iwait),  word_t'(e.e_iwait));
        cmp("dwait",    word_t'(dwait),  word_t'(e.e_dwait));
        cmp("ramREN",   word_t'(ramREN), word_t'(e.e_ren));
        cmp("ramWEN",   word_t'(ramWEN), word_t'(e.e_wen));
        cmp("ramaddr",  ramaddr,         e.e_addr);
        cmp("ramstore", ramstore,        e.e_store);
        cmp("iload",    iload,           e.e_iload);
        cmp("dload",    dload,           e.e_dload);
        row++;
    endtask

    initial begin
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = IA; daddr = DA; dstore = DS; ramload = RL; ramstate = FREE;

        // Reset with a pending fetch, then a fetch completing after one BUSY cycle
        vecs.push_back(mk(1,1,0,0,FREE,   1,0,0,0, 0, 0, 0, 0));
        vecs.push_back(mk(0,1,0,0,FREE,   1,0,0,0, 0, 0, 0, 0));
        vecs.push_back(mk(0,1,0,0,BUSY,   1,0,1,0, IA,0, 0, 0));
        vecs.push_back(mk(0,1,0,0,ACCESS, 0,0,1,0, IA,0, RL,0));
        vecs.push_back(mk(0,1,0,0,FREE,   1,0,0,0, 0, 0, 0, 0));

        // Simultaneous requests: data first, then instruction
        vecs.push_back(mk(1,1,1,0,FREE,   1,1,0,0, 0, 0, 0, 0));
        vecs.push_back(mk(0,1,1,0,FREE,   1,1,0,0, 0, 0, 0, 0));
        vecs.push_back(mk(0,1,1,0,ACCESS, 1,0,1,0, DA,DS,0, RL));
        vecs.push_back(mk(0,1,0,0,FREE,   1,0,0,0, 0, 0, 0, 0));
        vecs.push_back(mk(0,1,0,0,ACCESS, 0,0,1,0, IA,0, RL,0));

        // Write held through three BUSY cycles
        vecs.push_back(mk(1,0,0,1,FREE,   0,1,0,0, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,0,1,FREE,   0,1,0,0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0,0,0,1,BUSY, 0,1,0,1, DA,DS,0, 0));
        vecs.push_back(mk(0,0,0,1,ACCESS, 0,0,0,1, DA,DS,0, 0));

        // Data read withdrawn after an ERROR cycle, then a clean fetch from IDLE
        vecs.push_back(mk(1,0,1,0,FREE,   0,1,0,0, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,1,0,FREE,   0,1,0,0, 0, 0, 0, 0));
        vecs.push_back(mk(0,0,1,0,ERROR,  0,1,1,0, DA,DS,0, 0));
        vecs.push_back(mk(0,0,0,0,BUSY,   0,0,0,0, DA,DS,0, 0));
        vecs.push_back(mk(0,0,0,0,ACCESS, 0,0,0,0, 0, 0, 0, 0));
        vecs.push_back(mk(0,1,0,0,FREE,   1,0,0,0, 0, 0, 0, 0));
        vecs.push_back(mk(0,1,0,0,ACCESS, 0,0,1,0, IA,0, RL,0));

        // Starvation: four data grants, forced fetch, then data again
        vecs.push_back(mk(1,1,1,0,FREE,   1,1,0,0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) begin
            vecs.push_back(mk(0,1,1,0,FREE,   1,1,0,0, 0, 0, 0, 0));
            vecs.push_back(mk(0,1,1,0,ACCESS, 1,0,1,0, DA,DS,0, RL));
        end
        vecs.push_back(mk(0,1,1,0,FREE,   1,1,0,0, 0, 0, 0, 0));
        vecs.push_back(mk(0,1,1,0,ACCESS, 0,1,1,0, IA,0, RL,0));
        vecs.push_back(mk(0,1,1,0,FREE,   1,1,0,0, 0, 0, 0, 0));
        vecs.push_back(mk(0,1,1,0,ACCESS, 1,0,1,0, DA,DS,0, RL));

        foreach (vecs[k]) begin
            @(posedge CLK);
            #1;
            applyStimulus(vecs[k]);
            #3;
            checkOutput();
        end

        // Reset asserted in the middle of an instruction grant
        @(posedge CLK); #1; applyStimulus(mk(1,1,0,0,FREE, 1,0,0,0, 0, 0,0,0)); #3; checkOutput();
        @(posedge CLK); #1; applyStimulus(mk(0,1,0,0,FREE, 1,0,0,0, 0, 0,0,0)); #3; checkOutput();
        @(posedge CLK); #1; applyStimulus(mk(0,1,0,0,BUSY, 1,0,1,0, IA,0,0,0)); #3; checkOutput();
        applyStimulus(mk(1,1,0,0,BUSY, 1,0,0,0, 0, 0,0,0));
        #1;
        checkOutput();
        @(posedge CLK); #1; applyStimulus(mk(0,1,0,0,FREE,   1,0,0,0, 0, 0,0, 0)); #3; checkOutput();
        @(posedge CLK); #1; applyStimulus(mk(0,1,0,0,ACCESS, 0,0,1,0, IA,0,RL,0)); #3; checkOutput();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
